// File: rtl/otter_adc_pkg.sv
// Shared types and XADC DRP constants for the OTTER ADC scan controller.
package otter_adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StReq,
    StWaitRdy,
    StAccum,
    StDone
  } adc_state_t;

  localparam int unsigned AdcW     = 12;
  localparam int unsigned DrpAddrW = 7;
  localparam int unsigned DrpDataW = 16;

  // XADC DRP status register addresses
  localparam logic [DrpAddrW-1:0] XadcTemp   = 7'h00;
  localparam logic [DrpAddrW-1:0] XadcVccint = 7'h01;
  localparam logic [DrpAddrW-1:0] XadcVaux0  = 7'h10;

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// XADC DRP read port: controller is master, XADC primitive (or model) is slave.
interface adc_scan_ctrl_if;
  import otter_adc_pkg::*;

  logic                den;
  logic [DrpAddrW-1:0] daddr;
  logic [DrpDataW-1:0] dout;
  logic                drdy;

  modport master (
    output den,
    output daddr,
    input  dout,
    input  drdy
  );

  modport slave (
    input  den,
    input  daddr,
    output dout,
    output drdy
  );

endinterface

// File: rtl/tick_gen.sv
// Enable-gated divider: one-cycle tick every Div enabled cycles; counter clears when disabled.
module tick_gen #(
  parameter int unsigned Div = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scheduled XADC DRP scanner: one read outstanding, per-channel averaging over 2**AvgLog2 scans,
// sticky VALID/OVERRUN/DRP_ERR flags where a set always wins over a same-cycle clear.
module adc_scan_ctrl
  import otter_adc_pkg::*;
#(
  parameter int unsigned         NumCh     = 4,
  parameter logic [DrpAddrW-1:0] ChBase    = XadcVaux0,
  parameter int unsigned         SampleDiv = 50000,
  parameter int unsigned         AvgLog2   = 2,
  parameter int unsigned         DrpTmo    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_en_i,
  input  logic [NumCh-1:0]      cfg_mask_i,
  input  logic [NumCh-1:0]      clr_valid_i,
  input  logic                  clr_flags_i,
  adc_scan_ctrl_if.master       drp_if,
  output logic [AdcW*NumCh-1:0] result_o,
  output logic [NumCh-1:0]      valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  drp_err_o
);

  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned AccW = AdcW + AvgLog2;
  localparam int unsigned CntW = AvgLog2 + 1;
  localparam int unsigned TmoW = $clog2(DrpTmo + 1);

  localparam logic [CntW-1:0] CntLast = CntW'((1 << AvgLog2) - 1);
  // Fires so that DRP_ERR is visible exactly DrpTmo cycles after the DEN cycle
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DrpTmo - 2);

  function automatic logic [ChW-1:0] lowest_ch(input logic [NumCh-1:0] m);
    logic [ChW-1:0] idx = '0;
    for (int i = int'(NumCh) - 1; i >= 0; i--) begin
      if (m[i]) idx = ChW'(i);
    end
    return idx;
  endfunction

  function automatic logic [DrpAddrW-1:0] ch_addr(input logic [ChW-1:0] ch);
    return ChBase + DrpAddrW'(ch);
  endfunction

  adc_state_t                     state_q;
  logic                           den_q;
  logic [DrpAddrW-1:0]            daddr_q;
  logic [NumCh-1:0]               mask_q;
  logic [NumCh-1:0]               pend_q;
  logic [ChW-1:0]                 ch_q;
  logic [TmoW-1:0]                tmo_q;
  logic [AdcW-1:0]                sample_q;
  logic [NumCh-1:0][AccW-1:0]     acc_q;
  logic [CntW-1:0]                cnt_q;
  logic [NumCh-1:0][AdcW-1:0]     result_q;
  logic [NumCh-1:0]               valid_q;
  logic                           overrun_q;
  logic                           drp_err_q;

  logic                           tick;
  logic                           tick_en;
  logic [NumCh-1:0]               pend_rest;
  logic [ChW-1:0]                 first_ch;
  logic [ChW-1:0]                 next_ch;
  logic                           unused_dout_lsb;

  assign tick_en = cfg_en_i && (state_q != StIdle);

  tick_gen #(
    .Div (SampleDiv)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  always_comb begin
    pend_rest       = pend_q;
    pend_rest[ch_q] = 1'b0;
    first_ch        = lowest_ch(cfg_mask_i);
    next_ch         = lowest_ch(pend_rest);
  end

  assign busy_o = (state_q != StIdle) && (state_q != StWaitTick);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      den_q     <= 1'b0;
      daddr_q   <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      ch_q      <= '0;
      tmo_q     <= '0;
      sample_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= '0;
      overrun_q <= 1'b0;
      drp_err_q <= 1'b0;
    end else begin
      den_q   <= 1'b0;
      valid_q <= valid_q & ~clr_valid_i;
      if (clr_flags_i) begin
        overrun_q <= 1'b0;
        drp_err_q <= 1'b0;
      end
      // A tick during a scan is dropped; the scan itself is left alone
      if (tick && busy_o) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          acc_q  <= '0;
          cnt_q  <= '0;
          pend_q <= '0;
          if (cfg_en_i) state_q <= StWaitTick;
        end

        StWaitTick: begin
          if (!cfg_en_i) begin
            state_q <= StIdle;
          end else if (tick) begin
            mask_q <= cfg_mask_i;
            for (int unsigned i = 0; i < NumCh; i++) begin
              if (!cfg_mask_i[i]) acc_q[i] <= '0;
            end
            if (cfg_mask_i != '0) begin
              pend_q  <= cfg_mask_i;
              ch_q    <= first_ch;
              daddr_q <= ch_addr(first_ch);
              den_q   <= 1'b1;
              state_q <= StReq;
            end
          end
        end

        StReq: begin
          tmo_q   <= '0;
          state_q <= StWaitRdy;
        end

        StWaitRdy: begin
          if (drp_if.drdy) begin
            sample_q <= drp_if.dout[DrpDataW-1 -: AdcW];
            state_q  <= cfg_en_i ? StAccum : StIdle;
          end else if (tmo_q == TmoLast) begin
            drp_err_q <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= cfg_en_i ? StWaitTick : StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StAccum: begin
          acc_q[ch_q] <= acc_q[ch_q] + AccW'(sample_q);
          pend_q      <= pend_rest;
          if (!cfg_en_i) begin
            state_q <= StIdle;
          end else if (pend_rest != '0) begin
            ch_q    <= next_ch;
            daddr_q <= ch_addr(next_ch);
            den_q   <= 1'b1;
            state_q <= StReq;
          end else begin
            state_q <= StDone;
          end
        end

        StDone: begin
          if (cnt_q == CntLast) begin
            for (int unsigned i = 0; i < NumCh; i++) begin
              if (mask_q[i]) begin
                result_q[i] <= AdcW'(acc_q[i] >> AvgLog2);
                valid_q[i]  <= 1'b1;
              end
            end
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          state_q <= StWaitTick;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign drp_if.den   = den_q;
  assign drp_if.daddr = daddr_q;
  assign result_o     = result_q;
  assign valid_o      = valid_q;
  assign overrun_o    = overrun_q;
  assign drp_err_o    = drp_err_q;

  assign unused_dout_lsb = ^drp_if.dout[DrpDataW-AdcW-1:0];

endmodule
